// File: rtl/centroid_div_sequencer_if.sv
// centroid_div_sequencer_if: frame statistics in, centroid result and status out; master drives stats, slave is the sequencer
interface centroid_div_sequencer_if #(
  parameter int INPUT_WIDTH = 11,
  parameter int SUM_WIDTH   = 27,
  parameter int COUNT_WIDTH = 19
);
  logic                   enable;
  logic                   start;
  logic [SUM_WIDTH-1:0]   x_sum;
  logic [SUM_WIDTH-1:0]   y_sum;
  logic [COUNT_WIDTH-1:0] count;
  logic [INPUT_WIDTH-1:0] x_position;
  logic [INPUT_WIDTH-1:0] y_position;
  logic                   xy_valid;
  logic                   busy;
  logic                   overrun;
  modport master (
    output enable, start, x_sum, y_sum, count,
    input  x_position, y_position, xy_valid, busy, overrun
  );
  modport slave (
    input  enable, start, x_sum, y_sum, count,
    output x_position, y_position, xy_valid, busy, overrun
  );
endinterface

// File: rtl/centroid_div_sequencer.sv
// centroid_div_sequencer: one shared restoring divider computes x_sum/count then y_sum/count per frame (ports: clk, aresetn, bus slave)
module centroid_div_sequencer #(
  parameter int INPUT_WIDTH  = 11,
  parameter int SUM_WIDTH    = 27,
  parameter int COUNT_WIDTH  = 19,
  parameter int COUNT_THRESH = 40
) (
  input logic clk,
  input logic aresetn,
  centroid_div_sequencer_if.slave bus
);
  localparam int ITW = $clog2(SUM_WIDTH);
  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
  state_t                 state, nxt;
  logic [SUM_WIDTH-1:0]   y_snap, dvd, quo, q_n;
  logic [COUNT_WIDTH-1:0] dvs;
  logic [COUNT_WIDTH:0]   rem, rem_n;
  logic [COUNT_WIDTH+1:0] trial, diff;
  logic [ITW-1:0]         iter;
  logic [INPUT_WIDTH-1:0] x_res, q_sat;
  logic                   ge, last, below;
  assign below = bus.count < COUNT_WIDTH'(COUNT_THRESH);
  assign trial = {rem, dvd[SUM_WIDTH-1]};
  assign diff  = trial - (COUNT_WIDTH+2)'(dvs);
  assign ge    = trial >= (COUNT_WIDTH+2)'(dvs);
  assign rem_n = ge ? diff[COUNT_WIDTH:0] : trial[COUNT_WIDTH:0];
  assign q_n   = {quo[SUM_WIDTH-2:0], ge};
  assign q_sat = |q_n[SUM_WIDTH-1:INPUT_WIDTH] ? '1 : q_n[INPUT_WIDTH-1:0];
  assign last  = iter == '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (!bus.enable) nxt = IDLE;
    else if (state == IDLE) nxt = bus.start ? (below ? DONE : DIV_X) : IDLE;
    else if (state == DONE) nxt = IDLE;
    else if (last) nxt = state == DIV_X ? DIV_Y : DONE;
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      bus.x_position <= '0;
      bus.y_position <= '0;
      bus.xy_valid   <= 1'b0;
      bus.overrun    <= 1'b0;
      y_snap         <= '0;
      dvs            <= '0;
      rem            <= '0;
      dvd            <= '0;
      quo            <= '0;
      iter           <= '0;
      x_res          <= '0;
    end else if (!bus.enable) begin
      bus.x_position <= '0;
      bus.y_position <= '0;
      bus.xy_valid   <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.xy_valid <= 1'b0;
      bus.overrun  <= bus.start && state != IDLE;
      if (state == IDLE && bus.start) begin
        y_snap <= bus.y_sum;
        dvs    <= bus.count;
        rem    <= '0;
        dvd    <= bus.x_sum;
        iter   <= ITW'(SUM_WIDTH - 1);
        if (below) begin
          bus.x_position <= '1;
          bus.y_position <= '1;
          bus.xy_valid   <= 1'b1;
        end
      end else if (state == DIV_X || state == DIV_Y) begin
        rem  <= rem_n;
        dvd  <= {dvd[SUM_WIDTH-2:0], 1'b0};
        quo  <= q_n;
        iter <= iter - 1'b1;
        if (last && state == DIV_X) begin
          x_res <= q_sat;
          rem   <= '0;
          dvd   <= y_snap;
          iter  <= ITW'(SUM_WIDTH - 1);
        end else if (last) begin
          bus.x_position <= x_res;
          bus.y_position <= q_sat;
          bus.xy_valid   <= 1'b1;
        end
      end
    end
endmodule
